// File: rtl/game_tick_scheduler.sv
// Per-frame game update sequencer: frame-boundary or single-step trigger, per-player req/ack, resolve strobe.
// Optional step_btn debouncer is enabled with `define GAME_TICK_STEP_DEBOUNCE_EN.
module game_tick_scheduler #(
    parameter int NUM_PLAYERS    = 2,
    parameter int TRIGGER_LINE   = 480,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TICK_W         = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9:0]             pixel_y,
    input  logic                   run_mode,
    input  logic                   step_btn,
    output logic [NUM_PLAYERS-1:0] upd_req,
    input  logic [NUM_PLAYERS-1:0] upd_ack,
    output logic                   resolve_strobe,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   overrun,
    output logic [NUM_PLAYERS-1:0] timeout_err,
    output logic [TICK_W-1:0]      tick_count,
    output logic [2:0]             state_dbg
);

    localparam int IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLAYERS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        GAP     = 3'd2,
        RESOLVE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                 state, state_next;
    logic [IDX_W-1:0]       idx, idx_next;
    logic [CNT_W-1:0]       tcnt, tcnt_next;
    logic [NUM_PLAYERS-1:0] to_set;
    logic [9:0]             prev_y;
    logic                   prev_step;
    logic                   step_lvl;
    logic                   frame_trig, step_trig, accepted;

`ifdef GAME_TICK_STEP_DEBOUNCE_EN
    logic        step_raw_q, step_stable;
    logic [15:0] db_cnt;

    // Counter restarts on any raw change; the filtered level follows only after a full quiet period.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_raw_q  <= 1'b0;
            step_stable <= 1'b0;
            db_cnt      <= '0;
        end else if (step_btn != step_raw_q) begin
            step_raw_q <= step_btn;
            db_cnt     <= '0;
        end else if (step_stable != step_raw_q) begin
            if (db_cnt == 16'hFFFF) begin
                step_stable <= step_raw_q;
                db_cnt      <= '0;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end
    end

    assign step_lvl = step_stable;
`else
    assign step_lvl = step_btn;
`endif

    assign frame_trig = (pixel_y == 10'(TRIGGER_LINE)) && (prev_y != 10'(TRIGGER_LINE));
    assign step_trig  = step_lvl && !prev_step;
    assign accepted   = run_mode ? frame_trig : step_trig;
    assign state_dbg  = state;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        tcnt_next  = tcnt;
        to_set     = '0;
        case (state)
            IDLE: begin
                if (accepted) begin
                    state_next = REQ;
                    idx_next   = '0;
                    tcnt_next  = '0;
                end
            end
            REQ: begin
                // An ack in the final timeout cycle still counts as a clean handshake.
                if (upd_ack[idx]) begin
                    state_next = GAP;
                end else if (tcnt == TO_MAX) begin
                    to_set[idx] = 1'b1;
                    state_next  = GAP;
                end else begin
                    tcnt_next = tcnt + 1'b1;
                end
            end
            GAP: begin
                tcnt_next = '0;
                if (idx == LAST_IDX) begin
                    state_next = RESOLVE;
                end else begin
                    idx_next   = idx + 1'b1;
                    state_next = REQ;
                end
            end
            RESOLVE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            tcnt           <= '0;
            prev_y         <= '0;
            prev_step      <= 1'b0;
            upd_req        <= '0;
            resolve_strobe <= 1'b0;
            frame_done     <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
            timeout_err    <= '0;
            tick_count     <= '0;
        end else begin
            state          <= state_next;
            idx            <= idx_next;
            tcnt           <= tcnt_next;
            prev_y         <= pixel_y;
            prev_step      <= step_lvl;
            upd_req        <= (state_next == REQ) ? (NUM_PLAYERS'(1) << idx_next) : '0;
            resolve_strobe <= (state_next == RESOLVE);
            frame_done     <= (state_next == DONE);
            busy           <= (state_next != IDLE);
            timeout_err    <= timeout_err | to_set;
            if (accepted && (state != IDLE))
                overrun <= 1'b1;
            if (state_next == DONE)
                tick_count <= tick_count + 1'b1;
        end
    end

endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
Sequences one game-logic update per video frame. Detects a clean frame boundary from the VGA driver's line counter, or a single-step button press. Then runs a request/acknowledge update for each player in a fixed order, followed by a one-cycle collision/resolve strobe. Replaces the glitch-prone compare-derived game clock with a synchronous tick plus handshakes in the 25 MHz pixel-clock domain.

Parameters:
NUM_PLAYERS, 2, number of player update ports, served in index order 0..NUM_PLAYERS-1
TRIGGER_LINE, 480, value of pixel_y that marks the frame boundary (first blanking line)
TIMEOUT_CYCLES, 1024, max cycles to wait for an upd_ack before abandoning that player
TICK_W, 16, width of tick_count

Ports:
clk  input  1  25 MHz pixel clock
rst  input  1  synchronous, active-high reset
pixel_y  input  10  current line from the VGA driver
run_mode  input  1  1 = auto tick every frame, 0 = single-step mode
step_btn  input  1  active-high step request, already synchronised to clk
upd_req  output  NUM_PLAYERS  per-player update request
upd_ack  input  NUM_PLAYERS  per-player update acknowledge
resolve_strobe  output  1  one-cycle pulse after all player updates
frame_done  output  1  one-cycle pulse when the sequence completes
busy  output  1  high from trigger acceptance until frame_done
overrun  output  1  sticky: trigger arrived while busy
timeout_err  output  NUM_PLAYERS  sticky per-player timeout flags
tick_count  output  TICK_W  completed sequences, wraps modulo 2^TICK_W

Behaviour:
- Reset is synchronous and active-high; it is the only reset. All outputs are 0 on reset: upd_req, resolve_strobe, frame_done, busy, overrun, timeout_err, tick_count.
- Reset also sets the FSM to IDLE, the player index to 0, the timeout counter to 0, and prev_y/prev_step to 0.
- Reset mid-sequence drops upd_req on the next edge; no frame_done is emitted.
- Frame trigger: one-cycle internal pulse when pixel_y == TRIGGER_LINE and the registered prev_y != TRIGGER_LINE. Exactly one pulse per frame.
- Step trigger: rising edge of step_btn (step_btn=1, prev_step=0).
- Accepted trigger: frame trigger when run_mode=1; step trigger when run_mode=0. The trigger of the other kind is ignored.
- Overrun: an accepted-type trigger arriving while busy=1 sets overrun. That trigger is dropped, not queued. overrun clears only on rst.
- FSM states: IDLE, REQ, GAP, RESOLVE, DONE.
- IDLE: on an accepted trigger, go to REQ with idx=0. busy=1 from the next cycle.
- REQ: upd_req[idx]=1, all other bits 0; the timeout counter increments each cycle.
  - upd_ack[idx]=1 sampled → go to GAP; upd_req[idx] low from the next cycle.
  - Counter reaches TIMEOUT_CYCLES-1 without ack → set timeout_err[idx], go to GAP.
  - Ack and timeout in the same cycle: ack wins, no error flag.
  - upd_ack bits other than idx are ignored.
- GAP: one cycle with all upd_req low; counter cleared. If idx==NUM_PLAYERS-1 go to RESOLVE, else idx+1 and go to REQ.
- RESOLVE: resolve_strobe=1 for exactly one cycle; go to DONE.
- DONE: frame_done=1 for one cycle; tick_count+1; busy=0 from the next cycle; go to IDLE.
- Latency, trigger to first upd_req: 1 cycle. Minimum sequence with zero-wait acks: 2*NUM_PLAYERS+2 cycles after trigger, i.e. 6 cycles for 2 players.
- A run_mode change mid-sequence does not abort the sequence; it only affects later trigger acceptance.
- All outputs are registered.

Optional Feature:
- Macro: GAME_TICK_STEP_DEBOUNCE_EN.
- Defined: step_btn passes through a debouncer before edge detection. The filtered level changes only after step_btn has held a new value for 2^16 consecutive cycles. A 16-bit counter restarts on every raw change.
- Undefined: step_btn feeds the edge detector directly (bench default). Every raw rising edge is a step.

Test Plan:
- Auto tick: run_mode=1, pixel_y sweeps 0..524 twice, acks return 1 cycle after req. Expect upd_req=01 then 10, one resolve_strobe, one frame_done per frame, tick_count=2, overrun=0.
- Held line: pixel_y held at 480 for 800 cycles, instant acks. Expect exactly one sequence and tick_count=1.
- Single step: run_mode=0, frame triggers present, three step_btn pulses spaced 50 cycles apart. Expect tick_count=3; frame triggers cause nothing.
- Timeout: upd_ack[0] never asserted. Expect upd_req[0] high 1024 cycles, then timeout_err=01, then player 1 served, then frame_done. Expect tick_count=1.
- Overrun: upd_ack[1] delayed 600 cycles, step pulse issued mid-sequence in run_mode=0. Expect overrun=1, no second sequence, tick_count=1.
- Reset mid-REQ: assert rst while upd_req=01. Expect all outputs 0 on the next edge; a later trigger restarts at player 0.
